// File: rtl/dbus_arbiter.sv
// Two-port data-bus arbiter: page-table-walk port W and memory-stage port M share one data bus.
// Latency: grant is registered one cycle after a request in IDLE; oreq/iresp are combinational in grant states.
// Backpressure: a losing requester holds valid high until it is granted; the arbiter never queues requests.

package dbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        wr;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  ireq_w,
    output dbus_resp_t iresp_w,
    input  dbus_req_t  ireq_m,
    output dbus_resp_t iresp_m,
    output dbus_req_t  oreq,
    input  dbus_resp_t oresp,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_W = 2'd1,
        GNT_M = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t    state_q;
    state_t    state_d;
    logic      last_m_q;   // 1 = M was granted last, 0 = W
    logic      last_m_d;
    dbus_req_t hold_q;     // copy of the last presented request, replayed while draining

    // State and last-grant registers; reset aborts any transaction without draining.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_m_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_m_q <= last_m_d;
        end
    end

    // Hold register tracks oreq in every grant cycle so an abandoned request can be replayed verbatim.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_q <= '0;
        end else if (state_q == GNT_W || state_q == GNT_M) begin
            hold_q <= oreq;
        end
    end

    // Arbitration, bus muxing and next-state; completion wins over a same-cycle valid drop.
    always_comb begin
        state_d  = state_q;
        last_m_d = last_m_q;
        oreq     = '0;
        iresp_w  = '0;
        iresp_m  = '0;
        busy     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ireq_w.valid && ireq_m.valid) begin
                    state_d = (ROUND_ROBIN && last_m_q) ? GNT_W : GNT_M;
                end else if (ireq_w.valid) begin
                    state_d = GNT_W;
                end else if (ireq_m.valid) begin
                    state_d = GNT_M;
                end
            end
            GNT_W: begin
                busy       = 1'b1;
                oreq       = ireq_w;
                oreq.valid = 1'b1;
                iresp_w    = oresp;
                if (oresp.data_ok) begin
                    state_d  = IDLE;
                    last_m_d = 1'b0;
                end else if (!ireq_w.valid) begin
                    state_d = DRAIN;
                end
            end
            GNT_M: begin
                busy       = 1'b1;
                oreq       = ireq_m;
                oreq.valid = 1'b1;
                iresp_m    = oresp;
                if (oresp.data_ok) begin
                    state_d  = IDLE;
                    last_m_d = 1'b1;
                end else if (!ireq_m.valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy       = 1'b1;
                oreq       = hold_q;
                oreq.valid = 1'b1;
                if (oresp.data_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: per-cycle vector table against the round-robin instance,
// plus a hand-written fixed-priority sequence against a second instance.
// Inputs change 1 time unit after posedge; outputs are compared on the negedge.

module tb_dbus_arbiter;
    import dbus_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  ireq_w, ireq_m;
    dbus_resp_t oresp;

    dbus_req_t  oreq1, oreq0;
    dbus_resp_t iresp_w1, iresp_m1, iresp_w0, iresp_m0;
    logic       busy1, busy0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dbus_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .reset(reset),
        .ireq_w(ireq_w), .iresp_w(iresp_w1),
        .ireq_m(ireq_m), .iresp_m(iresp_m1),
        .oreq(oreq1), .oresp(oresp), .busy(busy1)
    );

    dbus_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .ireq_w(ireq_w), .iresp_w(iresp_w0),
        .ireq_m(ireq_m), .iresp_m(iresp_m0),
        .oreq(oreq0), .oresp(oresp), .busy(busy0)
    );

    typedef struct {
        logic       rst;
        dbus_req_t  iw;
        dbus_req_t  im;
        dbus_resp_t rs;
        dbus_req_t  e_oreq;
        dbus_resp_t e_w;
        dbus_resp_t e_m;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic dbus_req_t rq(logic v, logic wr, logic [63:0] a, logic [63:0] wd);
        dbus_req_t r;
        r.valid = v;
        r.wr    = wr;
        r.size  = 3'd3;
        r.addr  = a;
        r.wstrb = wr ? 8'hFF : 8'h00;
        r.wdata = wd;
        return r;
    endfunction

    function automatic dbus_resp_t rp(logic aok, logic dok, logic [63:0] d);
        dbus_resp_t r;
        r.addr_ok = aok;
        r.data_ok = dok;
        r.data    = d;
        return r;
    endfunction

    function void add(logic rst, dbus_req_t iw, dbus_req_t im, dbus_resp_t rs,
                      dbus_req_t eo, dbus_resp_t ew, dbus_resp_t em, logic eb);
        vec_t v;
        v.rst = rst; v.iw = iw; v.im = im; v.rs = rs;
        v.e_oreq = eo; v.e_w = ew; v.e_m = em; v.e_busy = eb;
        vecs.push_back(v);
    endfunction

    task automatic chk_req(string nm, dbus_req_t act, dbus_req_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk_resp(string nm, dbus_resp_t act, dbus_resp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk_bit(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b", nm, act, exp);
        end
    endtask

    // Hard stop so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dbus_req_t  z, w1, w0, mb1, ma1, ma0, w2, w20;
        dbus_resp_t n;
        logic [63:0] wa, ma, mb, wa2, dd;

        wa  = 64'h8000_1000;
        ma  = 64'h8000_2000;
        mb  = 64'h8000_3000;
        wa2 = 64'h8000_4000;
        dd  = 64'hDEAD_BEEF;
        z   = '0;
        n   = '0;
        w1  = rq(1'b1, 1'b0, wa,  64'h0);
        w0  = rq(1'b0, 1'b0, wa,  64'h0);
        mb1 = rq(1'b1, 1'b1, mb,  64'h0000_1234_5678_9ABC);
        ma1 = rq(1'b1, 1'b1, ma,  64'hCAFE_F00D_0000_5555);
        ma0 = rq(1'b0, 1'b1, ma,  64'hCAFE_F00D_0000_5555);
        w2  = rq(1'b1, 1'b0, wa2, 64'h0);
        w20 = rq(1'b0, 1'b0, wa2, 64'h0);

        // rst   ireq_w ireq_m  oresp                    exp oreq  exp iresp_w              exp iresp_m              busy
        add(1'b0, z,   z,   n,                          z,   n,                          n,                          1'b0); // 0 in reset
        add(1'b1, w1,  z,   n,                          z,   n,                          n,                          1'b0); // 1 lone W, IDLE
        add(1'b1, w1,  z,   rp(1'b1, 1'b0, 64'h0),      w1,  rp(1'b1, 1'b0, 64'h0),      n,                          1'b1); // 2 addr_ok fwd
        add(1'b1, w1,  z,   n,                          w1,  n,                          n,                          1'b1); // 3
        add(1'b1, w1,  z,   rp(1'b0, 1'b1, dd),         w1,  rp(1'b0, 1'b1, dd),         n,                          1'b1); // 4 data_ok
        add(1'b1, z,   z,   n,                          z,   n,                          n,                          1'b0); // 5 busy falls
        add(1'b0, w1,  mb1, n,                          z,   n,                          n,                          1'b0); // 6 reset, tie pending
        add(1'b1, w1,  mb1, n,                          z,   n,                          n,                          1'b0); // 7 IDLE
        add(1'b1, w1,  mb1, rp(1'b1, 1'b1, 64'h11),     mb1, n,                          rp(1'b1, 1'b1, 64'h11),     1'b1); // 8 M first
        add(1'b1, w1,  mb1, n,                          z,   n,                          n,                          1'b0); // 9 gap
        add(1'b1, w1,  mb1, rp(1'b0, 1'b1, 64'h22),     w1,  rp(1'b0, 1'b1, 64'h22),     n,                          1'b1); // 10 W second
        add(1'b1, w1,  mb1, n,                          z,   n,                          n,                          1'b0); // 11 gap
        add(1'b1, w1,  mb1, rp(1'b0, 1'b1, 64'h33),     mb1, n,                          rp(1'b0, 1'b1, 64'h33),     1'b1); // 12 M third
        add(1'b1, w1,  mb1, n,                          z,   n,                          n,                          1'b0); // 13 gap
        add(1'b1, w1,  mb1, rp(1'b0, 1'b1, 64'h44),     w1,  rp(1'b0, 1'b1, 64'h44),     n,                          1'b1); // 14 W fourth
        add(1'b1, z,   ma1, n,                          z,   n,                          n,                          1'b0); // 15 M request
        add(1'b1, z,   ma1, n,                          ma1, n,                          n,                          1'b1); // 16 GNT_M cyc0
        add(1'b1, z,   ma0, n,                          ma1, n,                          n,                          1'b1); // 17 abandon cyc1
        add(1'b1, z,   z,   n,                          ma1, n,                          n,                          1'b1); // 18 DRAIN cyc2
        add(1'b1, z,   z,   rp(1'b1, 1'b0, 64'h0),      ma1, n,                          n,                          1'b1); // 19 DRAIN cyc3
        add(1'b1, z,   z,   rp(1'b0, 1'b1, dd),         ma1, n,                          n,                          1'b1); // 20 DRAIN cyc4, discard
        add(1'b1, z,   z,   n,                          z,   n,                          n,                          1'b0); // 21 IDLE
        add(1'b1, w1,  z,   n,                          z,   n,                          n,                          1'b0); // 22
        add(1'b1, w0,  z,   n,                          w1,  n,                          n,                          1'b1); // 23 abandon W
        add(1'b0, z,   z,   n,                          w1,  n,                          n,                          1'b1); // 24 DRAIN, reset low
        add(1'b1, z,   z,   n,                          z,   n,                          n,                          1'b0); // 25 IDLE after reset
        add(1'b1, w2,  z,   n,                          z,   n,                          n,                          1'b0); // 26
        add(1'b1, w20, z,   rp(1'b0, 1'b1, 64'h55),     w2,  rp(1'b0, 1'b1, 64'h55),     n,                          1'b1); // 27 drop+data_ok
        add(1'b1, z,   z,   n,                          z,   n,                          n,                          1'b0); // 28 IDLE, not DRAIN

        reset  = 1'b0;
        ireq_w = '0;
        ireq_m = '0;
        oresp  = '0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            #1;
            reset  = vecs[i].rst;
            ireq_w = vecs[i].iw;
            ireq_m = vecs[i].im;
            oresp  = vecs[i].rs;
            @(negedge clk);
            chk_req (.nm($sformatf("v%0d_oreq", i)),    .act(oreq1),    .exp(vecs[i].e_oreq));
            chk_resp(.nm($sformatf("v%0d_iresp_w", i)), .act(iresp_w1), .exp(vecs[i].e_w));
            chk_resp(.nm($sformatf("v%0d_iresp_m", i)), .act(iresp_m1), .exp(vecs[i].e_m));
            chk_bit (.nm($sformatf("v%0d_busy", i)),    .act(busy1),    .exp(vecs[i].e_busy));
            @(posedge clk);
        end

        // Fixed priority: both held valid, M wins three times in a row while W waits.
        #1;
        reset  = 1'b0;
        ireq_w = w1;
        ireq_m = mb1;
        oresp  = '0;
        @(posedge clk);
        for (int t = 0; t < 3; t++) begin
            #1;
            reset = 1'b1;
            oresp = '0;
            @(negedge clk);
            chk_bit($sformatf("fp%0d_idle_valid", t), oreq0.valid, 1'b0);
            chk_bit($sformatf("fp%0d_idle_busy", t), busy0, 1'b0);
            @(posedge clk);
            #1;
            oresp = rp(1'b1, 1'b1, 64'hF0 + 64'(t));
            @(negedge clk);
            chk_req ($sformatf("fp%0d_oreq", t), oreq0, mb1);
            chk_resp($sformatf("fp%0d_iresp_m", t), iresp_m0, rp(1'b1, 1'b1, 64'hF0 + 64'(t)));
            chk_resp($sformatf("fp%0d_iresp_w", t), iresp_w0, n);
            chk_bit ($sformatf("fp%0d_busy", t), busy0, 1'b1);
            @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
